// File: rtl/seq_detect_ctrl_if.sv
// Config, control, serial-stream and status bundle for seq_detect_ctrl.
// master drives config/stream, slave is the detector controller.
interface seq_detect_ctrl_if #(
  parameter int unsigned MAX_LEN = 8,
  parameter int unsigned LEN_W   = 4,
  parameter int unsigned CNT_W   = 8
);
  logic               cfg_we;
  logic [MAX_LEN-1:0] cfg_pattern;
  logic [LEN_W-1:0]   cfg_len;
  logic [CNT_W-1:0]   cfg_target;
  logic               start;
  logic               abort;
  logic               w;
  logic               w_valid;
  logic               busy;
  logic               z;
  logic [CNT_W-1:0]   hit_count;
  logic               done;
  logic               timeout;

  modport master (
    output cfg_we, cfg_pattern, cfg_len, cfg_target, start, abort, w, w_valid,
    input  busy, z, hit_count, done, timeout
  );

  modport slave (
    input  cfg_we, cfg_pattern, cfg_len, cfg_target, start, abort, w, w_valid,
    output busy, z, hit_count, done, timeout
  );
endinterface

// File: rtl/seq_detect_ctrl.sv
// Programmable serial-pattern detector controller: counts (overlapping) pattern hits until a
// target is reached. Define SEQ_CTRL_TIMEOUT_EN to add the idle-beat watchdog and TIMEOUT_CYC.
module seq_detect_ctrl #(
  parameter int unsigned MAX_LEN     = 8,
  parameter int unsigned LEN_W       = 4,
  parameter int unsigned CNT_W       = 8
`ifdef SEQ_CTRL_TIMEOUT_EN
  ,
  parameter int unsigned TIMEOUT_CYC = 64
`endif
) (
  input logic              clk,
  input logic              rst,
  seq_detect_ctrl_if.slave bus
);

  typedef enum logic [1:0] {StIdle, StArm, StRun, StDone} state_e;

  state_e             state_q;
  logic [MAX_LEN-1:0] pattern_q;
  logic [MAX_LEN-2:0] history_q;  // newest bit arrives via w, so MAX_LEN-1 stored bits suffice
  logic [LEN_W-1:0]   len_q;
  logic [LEN_W-1:0]   fill_q;
  logic [CNT_W-1:0]   target_q;
  logic [CNT_W-1:0]   hit_count_q;
  logic               z_q;

  logic               busy;
  logic               cfg_load;
  logic               beat;
  logic               hit;
  logic [LEN_W-1:0]   cfg_len_clamped;
  logic [LEN_W-1:0]   fill_next;
  logic [MAX_LEN-1:0] history_next;
  logic [MAX_LEN-1:0] len_mask;
  logic [CNT_W-1:0]   count_next;

  assign busy     = (state_q == StArm) || (state_q == StRun);
  assign cfg_load = bus.cfg_we && !busy;
  assign beat     = (state_q == StRun) && bus.w_valid;

  always_comb begin
    if (bus.cfg_len == '0) begin
      cfg_len_clamped = LEN_W'(1);
    end else if (bus.cfg_len > LEN_W'(MAX_LEN)) begin
      cfg_len_clamped = LEN_W'(MAX_LEN);
    end else begin
      cfg_len_clamped = bus.cfg_len;
    end
  end

  always_comb begin
    len_mask = '0;
    for (int unsigned i = 0; i < MAX_LEN; i++) begin
      len_mask[i] = (i < 32'(len_q));
    end
  end

  assign history_next = {history_q, bus.w};
  assign fill_next    = (fill_q >= len_q) ? len_q : fill_q + LEN_W'(1);
  assign hit          = beat && (fill_next == len_q) &&
                        ((history_next & len_mask) == (pattern_q & len_mask));
  assign count_next   = (&hit_count_q) ? hit_count_q : hit_count_q + CNT_W'(1);

`ifdef SEQ_CTRL_TIMEOUT_EN
  localparam int unsigned WdW = $clog2(TIMEOUT_CYC + 1);

  logic [WdW-1:0] wdog_q;
  logic           timeout_q;
  logic           expire;

  assign expire = beat && !hit && ((32'(wdog_q) + 32'd1) >= TIMEOUT_CYC);
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      pattern_q   <= '0;
      history_q   <= '0;
      len_q       <= LEN_W'(1);
      fill_q      <= '0;
      target_q    <= '0;
      hit_count_q <= '0;
      z_q         <= 1'b0;
`ifdef SEQ_CTRL_TIMEOUT_EN
      wdog_q      <= '0;
      timeout_q   <= 1'b0;
`endif
    end else begin
      z_q <= 1'b0;
      if (cfg_load) begin
        pattern_q <= bus.cfg_pattern;
        len_q     <= cfg_len_clamped;
        target_q  <= bus.cfg_target;
      end
      if (bus.abort) begin
        state_q <= StIdle;
      end else begin
        unique case (state_q)
          StIdle, StDone: begin
            if (bus.start) begin
              state_q     <= StArm;
              history_q   <= '0;
              fill_q      <= '0;
              hit_count_q <= '0;
`ifdef SEQ_CTRL_TIMEOUT_EN
              timeout_q   <= 1'b0;
`endif
            end
          end
          StArm: begin
            state_q <= (target_q == '0) ? StDone : StRun;
`ifdef SEQ_CTRL_TIMEOUT_EN
            wdog_q  <= '0;
`endif
          end
          StRun: begin
            if (beat) begin
              history_q <= history_next[MAX_LEN-2:0];
              fill_q    <= fill_next;
              if (hit) begin
                z_q         <= 1'b1;
                hit_count_q <= count_next;
                if (count_next == target_q) begin
                  state_q <= StDone;
                end
`ifdef SEQ_CTRL_TIMEOUT_EN
                wdog_q <= '0;
              end else begin
                wdog_q <= wdog_q + WdW'(1);
                if (expire) begin
                  state_q   <= StDone;
                  timeout_q <= 1'b1;
                end
`endif
              end
            end
          end
          default: state_q <= StIdle;
        endcase
      end
    end
  end

  assign bus.busy      = busy;
  assign bus.z         = z_q;
  assign bus.hit_count = hit_count_q;
  assign bus.done      = (state_q == StDone);
`ifdef SEQ_CTRL_TIMEOUT_EN
  assign bus.timeout   = timeout_q;
`else
  assign bus.timeout   = 1'b0;
`endif

endmodule

// File: tb/tb_seq_detect_ctrl.sv
// Directed self-checking bench for seq_detect_ctrl; covers the watchdog when
// SEQ_CTRL_TIMEOUT_EN is defined (TIMEOUT_CYC = 4).
module tb_seq_detect_ctrl;
  localparam int unsigned MaxLen = 8;
  localparam int unsigned LenW   = 4;
  localparam int unsigned CntW   = 8;

  logic clk = 1'b0;
  logic rst;
  int   checks   = 0;
  int   failures = 0;

  logic [0:5] s1 = 6'b100100;
  logic [0:5] z1 = 6'b001001;
  int         c1[6] = '{0, 0, 1, 1, 1, 2};
  logic [0:6] s2 = 7'b1010101;
  logic [0:6] z2 = 7'b0010101;
  int         c2[7] = '{0, 0, 1, 1, 2, 2, 3};

  seq_detect_ctrl_if #(.MAX_LEN(MaxLen), .LEN_W(LenW), .CNT_W(CntW)) bus ();

  seq_detect_ctrl #(
    .MAX_LEN(MaxLen),
    .LEN_W  (LenW),
    .CNT_W  (CntW)
`ifdef SEQ_CTRL_TIMEOUT_EN
    ,
    .TIMEOUT_CYC(4)
`endif
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic outs(input string tag, input logic b, input logic zz, input logic d,
                      input int cnt);
    check({tag, ".busy"}, 32'(bus.busy), 32'(b));
    check({tag, ".z"}, 32'(bus.z), 32'(zz));
    check({tag, ".done"}, 32'(bus.done), 32'(d));
    check({tag, ".cnt"}, 32'(bus.hit_count), 32'(cnt));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic go(input logic we, input logic [7:0] pat, input logic [3:0] len,
                    input logic [7:0] tgt);
    bus.cfg_we      = we;
    bus.cfg_pattern = pat;
    bus.cfg_len     = len;
    bus.cfg_target  = tgt;
    bus.start       = 1'b1;
    tick();
    bus.start  = 1'b0;
    bus.cfg_we = 1'b0;
  endtask

  task automatic beat(input logic b);
    bus.w       = b;
    bus.w_valid = 1'b1;
    tick();
    bus.w_valid = 1'b0;
  endtask

  initial begin
    rst             = 1'b1;
    bus.cfg_we      = 1'b0;
    bus.cfg_pattern = '0;
    bus.cfg_len     = '0;
    bus.cfg_target  = '0;
    bus.start       = 1'b0;
    bus.abort       = 1'b0;
    bus.w           = 1'b0;
    bus.w_valid     = 1'b0;
    tick();
    tick();
    outs("rst", 1'b0, 1'b0, 1'b0, 0);
    check("rst.timeout", 32'(bus.timeout), 32'd0);
    rst = 1'b0;

    // 1: pattern 100, target 2, config loaded together with start
    go(1'b1, 8'b100, 4'd3, 8'd2);
    outs("t1.arm", 1'b1, 1'b0, 1'b0, 0);
    tick();
    for (int i = 0; i < 6; i++) begin
      beat(s1[i]);
      check($sformatf("t1.z%0d", i), 32'(bus.z), 32'(z1[i]));
      check($sformatf("t1.cnt%0d", i), 32'(bus.hit_count), 32'(c1[i]));
    end
    outs("t1.end", 1'b0, 1'b1, 1'b1, 2);
    tick();
    outs("t1.hold", 1'b0, 1'b0, 1'b1, 2);

    // 2: overlapping 101 hits, restarted from DONE
    go(1'b1, 8'b101, 4'd3, 8'd3);
    outs("t2.arm", 1'b1, 1'b0, 1'b0, 0);
    tick();
    for (int i = 0; i < 7; i++) begin
      beat(s2[i]);
      check($sformatf("t2.z%0d", i), 32'(bus.z), 32'(z2[i]));
      check($sformatf("t2.cnt%0d", i), 32'(bus.hit_count), 32'(c2[i]));
    end
    outs("t2.end", 1'b0, 1'b1, 1'b1, 3);

    // 3: test 1 stretched by idle cycles with random w
    go(1'b1, 8'b100, 4'd3, 8'd2);
    tick();
    for (int i = 0; i < 6; i++) begin
      beat(s1[i]);
      check($sformatf("t3.z%0d", i), 32'(bus.z), 32'(z1[i]));
      check($sformatf("t3.cnt%0d", i), 32'(bus.hit_count), 32'(c1[i]));
      bus.w = 1'($urandom);
      tick();
      check($sformatf("t3.idlez%0d", i), 32'(bus.z), 32'd0);
      check($sformatf("t3.idlecnt%0d", i), 32'(bus.hit_count), 32'(c1[i]));
    end
    check("t3.done", 32'(bus.done), 32'd1);

    // 4: reset right after the first hit, then run with reset config
    go(1'b0, 8'h00, 4'd0, 8'd0);
    tick();
    beat(1'b1);
    beat(1'b0);
    beat(1'b0);
    outs("t4.hit", 1'b1, 1'b1, 1'b0, 1);
    rst = 1'b1;
    tick();
    outs("t4.rst", 1'b0, 1'b0, 1'b0, 0);
    check("t4.timeout", 32'(bus.timeout), 32'd0);
    rst = 1'b0;
    go(1'b0, 8'h00, 4'd0, 8'd0);
    outs("t4.arm", 1'b1, 1'b0, 1'b0, 0);
    tick();
    outs("t4.done", 1'b0, 1'b0, 1'b1, 0);

    // 5: cfg_we while busy ignored, abort holds count, start clears it
    go(1'b1, 8'b100, 4'd3, 8'd2);
    tick();
    beat(1'b1);
    beat(1'b0);
    beat(1'b0);
    check("t5.cnt", 32'(bus.hit_count), 32'd1);
    bus.cfg_we      = 1'b1;
    bus.cfg_pattern = 8'b11111;
    bus.cfg_len     = 4'd5;
    bus.cfg_target  = 8'd1;
    tick();
    bus.cfg_we = 1'b0;
    bus.abort  = 1'b1;
    tick();
    bus.abort = 1'b0;
    outs("t5.abort", 1'b0, 1'b0, 1'b0, 1);
    go(1'b0, 8'h00, 4'd0, 8'd0);
    outs("t5.arm", 1'b1, 1'b0, 1'b0, 0);
    tick();
    beat(1'b1);
    beat(1'b0);
    beat(1'b0);
    outs("t5.hit", 1'b1, 1'b1, 1'b0, 1);
    bus.abort = 1'b1;
    tick();
    // abort wins over a simultaneous start
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    bus.abort = 1'b0;
    outs("t5.abst", 1'b0, 1'b0, 1'b0, 1);

    // len 0 behaves as len 1
    go(1'b1, 8'h01, 4'd0, 8'd1);
    tick();
    beat(1'b0);
    outs("len0.b0", 1'b1, 1'b0, 1'b0, 0);
    beat(1'b1);
    outs("len0.b1", 1'b0, 1'b1, 1'b1, 1);

    // 6: watchdog
    go(1'b1, 8'b100, 4'd3, 8'd2);
    tick();
    beat(1'b1);
    beat(1'b1);
    beat(1'b1);
    outs("t6.b3", 1'b1, 1'b0, 1'b0, 0);
    beat(1'b1);
`ifdef SEQ_CTRL_TIMEOUT_EN
    outs("t6.b4", 1'b0, 1'b0, 1'b1, 0);
    check("t6.timeout", 32'(bus.timeout), 32'd1);
    go(1'b0, 8'h00, 4'd0, 8'd0);
    check("t6.clr", 32'(bus.timeout), 32'd0);
`else
    outs("t6.b4", 1'b1, 1'b0, 1'b0, 0);
    check("t6.timeout", 32'(bus.timeout), 32'd0);
`endif
    bus.abort = 1'b1;
    tick();
    bus.abort = 1'b0;
    check("t6.idle", 32'(bus.busy), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
